axi_master_resp_rx: RTL

AXI_MASTER_RESP_RX -- requirements
Module: axi_master_resp_rx

---
 rtl/axi_slave_package.sv | 49 ++++
 rtl/axi_resp_sync_fifo.sv | 59 +++++
 rtl/axi_master_resp_rx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_package.sv
`default_nettype none
// ============================================================================
// Module   : axi_slave_package
// Purpose  : Shared channel typedefs, receive-FSM state encoding and a burst
//            length check helper for the AXI master response receiver.
// Revision : 1.0 - initial release
// ============================================================================
package axi_slave_package;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_RESP_W = 2;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_RESP_W-1:0] resp;
        logic                  valid;
    } B_Channel_Slv_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_RESP_W-1:0] resp;
        logic                  last;
        logic                  valid;
    } R_Channel_Slv_t;

    typedef struct packed {
        logic ready;
    } B_Channel_Msr_t;

    typedef struct packed {
        logic ready;
    } R_Channel_Msr_t;

    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_BURST = 1'b1
    } rx_state_t;

    // cnt is the zero-based index of the beat being accepted; ARLEN is beats-1.
    function automatic logic len_mismatch(input logic       last,
                                          input logic [7:0] cnt,
                                          input logic [7:0] len);
        return last ? (cnt != len) : (cnt == len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_resp_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axi_resp_sync_fifo
// Purpose  : Single-clock FIFO with combinational head; push accepted when
//            full if a pop happens in the same cycle. DEPTH: power of 2, >= 2.
// Revision : 1.0 - initial release
// ============================================================================
module axi_resp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra MSB distinguishes full (MSBs differ) from empty (pointers equal).
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_master_resp_rx.sv
`default_nettype none
// ============================================================================
// Module   : axi_master_resp_rx
// Purpose  : AXI master-side B/R response receiver with buffering and burst
//            length / ID checking against the issued AR stream.
// Revision : 1.0 - initial release
// ============================================================================
module axi_master_resp_rx
    import axi_slave_package::*;
#(
    parameter int ID_WIDTH    = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int RFIFO_DEPTH = 4,
    parameter int EXP_DEPTH   = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // B channel
    input  logic [ID_WIDTH-1:0]   BID,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    // R channel
    input  logic [ID_WIDTH-1:0]   RID,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY,
    // Expected-burst queue
    input  logic                  exp_push,
    input  logic [ID_WIDTH-1:0]   exp_id,
    input  logic [7:0]            exp_len,
    output logic                  exp_full,
    // Buffered B out
    output logic                  b_out_valid,
    output logic [ID_WIDTH-1:0]   b_out_id,
    output logic [1:0]            b_out_resp,
    input  logic                  b_out_ready,
    // Buffered R out
    output logic                  r_out_valid,
    output logic [ID_WIDTH-1:0]   r_out_id,
    output logic [DATA_WIDTH-1:0] r_out_data,
    output logic [1:0]            r_out_resp,
    output logic                  r_out_last,
    input  logic                  r_out_ready,
    // Protocol error pulses
    output logic                  err_len,
    output logic                  err_id
);

    localparam int EXP_W = ID_WIDTH + 8;
    localparam int RF_W  = ID_WIDTH + DATA_WIDTH + 3;

    localparam logic [0:0] ST_IDLE  = RX_IDLE;
    localparam logic [0:0] ST_BURST = RX_BURST;

    // ------------------------------------------------------------------
    // B path: single holding register
    // ------------------------------------------------------------------
    logic                r_b_valid;
    logic [ID_WIDTH-1:0] r_b_id;
    logic [1:0]          r_b_resp;
    logic                w_b_push;
    logic                w_b_pop;

    assign BREADY      = ~r_b_valid | b_out_ready;
    assign w_b_push    = BVALID & BREADY;
    assign w_b_pop     = r_b_valid & b_out_ready;
    assign b_out_valid = r_b_valid;
    assign b_out_id    = r_b_id;
    assign b_out_resp  = r_b_resp;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_b_valid <= 1'b0;
            r_b_id    <= '0;
            r_b_resp  <= '0;
        end else if (w_b_push) begin
            r_b_valid <= 1'b1;
            r_b_id    <= BID;
            r_b_resp  <= BRESP;
        end else if (w_b_pop) begin
            r_b_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Expected-burst queue and R beat buffer
    // ------------------------------------------------------------------
    logic [EXP_W-1:0]    w_exp_head;
    logic                w_exp_empty;
    logic                w_exp_pop;
    logic [ID_WIDTH-1:0] w_exp_head_id;
    logic [7:0]          w_exp_head_len;
    logic [RF_W-1:0]     w_rf_head;
    logic                w_rf_full;
    logic                w_rf_empty;
    logic                w_r_beat;

    axi_resp_sync_fifo #(
        .WIDTH (EXP_W),
        .DEPTH (EXP_DEPTH)
    ) u_exp_fifo (
        .clk     (ACLK),
        .rst_n   (ARESETn),
        .i_push  (exp_push),
        .i_data  ({exp_id, exp_len}),
        .i_pop   (w_exp_pop),
        .o_data  (w_exp_head),
        .o_full  (exp_full),
        .o_empty (w_exp_empty)
    );

    axi_resp_sync_fifo #(
        .WIDTH (RF_W),
        .DEPTH (RFIFO_DEPTH)
    ) u_r_fifo (
        .clk     (ACLK),
        .rst_n   (ARESETn),
        .i_push  (w_r_beat),
        .i_data  ({RID, RDATA, RRESP, RLAST}),
        .i_pop   (r_out_ready),
        .o_data  (w_rf_head),
        .o_full  (w_rf_full),
        .o_empty (w_rf_empty)
    );

    assign w_exp_head_id  = w_exp_head[EXP_W-1:8];
    assign w_exp_head_len = w_exp_head[7:0];
    assign r_out_valid    = ~w_rf_empty;
    assign {r_out_id, r_out_data, r_out_resp, r_out_last} = w_rf_head;

    // ------------------------------------------------------------------
    // R burst FSM
    // ------------------------------------------------------------------
    logic [0:0]          r_state;
    logic [ID_WIDTH-1:0] r_exp_id;
    logic [7:0]          r_exp_len;
    logic [7:0]          r_cnt;
    logic                r_err_len;
    logic                r_err_id;

    assign RREADY    = (r_state == ST_BURST) & ~w_rf_full;
    assign w_r_beat  = RVALID & RREADY;
    assign w_exp_pop = w_r_beat & RLAST;
    assign err_len   = r_err_len;
    assign err_id    = r_err_id;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= ST_IDLE;
            r_exp_id  <= '0;
            r_exp_len <= '0;
            r_cnt     <= '0;
            r_err_len <= 1'b0;
            r_err_id  <= 1'b0;
        end else begin
            r_err_len <= w_r_beat & len_mismatch(RLAST, r_cnt, r_exp_len);
            r_err_id  <= w_r_beat & (RID != r_exp_id);
            case (r_state)
                ST_IDLE: begin
                    if (!w_exp_empty) begin
                        r_state   <= ST_BURST;
                        r_exp_id  <= w_exp_head_id;
                        r_exp_len <= w_exp_head_len;
                        r_cnt     <= '0;
                    end
                end
                ST_BURST: begin
                    // A wrong length is only flagged; RLAST alone closes the burst.
                    if (w_r_beat) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (RLAST) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
